// File: rtl/mm_iddmm_arbiter.sv
// mm_iddmm_arbiter: round-robin front end that shares one mm_iddmm_top
// Montgomery multiplier between NREQ requesters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req/req_type              per-requester request level and mm_type
//   req_x/_valid, req_y/_valid per-requester operand word streams
//   gnt                       one-hot one-cycle grant pulse
//   rsp_data/rsp_valid        result word (shared) and one-hot valid, passthrough
//   busy                      high whenever not IDLE
//   err                       one-hot timeout-abort pulse
//   mm_type/mm_start/mm_x/mm_x_valid/mm_y/mm_y_valid  to the multiplier
//   mm_result/mm_valid        from the multiplier
//
// Optional feature macro: MM_ARB_TIMEOUT_EN -- aborts a WAIT that lasts
// TIMEOUT cycles and pulses err for the owner. Undefined: err is always 0.
module mm_iddmm_arbiter #(
  parameter int unsigned K       = 256,
  parameter int unsigned N       = 16,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_type,
  input  logic [K*NREQ-1:0]    req_x,
  input  logic [NREQ-1:0]      req_x_valid,
  input  logic [K*NREQ-1:0]    req_y,
  input  logic [NREQ-1:0]      req_y_valid,
  output logic [NREQ-1:0]      gnt,
  output logic [K-1:0]         rsp_data,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 busy,
  output logic [NREQ-1:0]      err,
  output logic [1:0]           mm_type,
  output logic                 mm_start,
  output logic [K-1:0]         mm_x,
  output logic                 mm_x_valid,
  output logic [K-1:0]         mm_y,
  output logic                 mm_y_valid,
  input  logic [K-1:0]         mm_result,
  input  logic                 mm_valid
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets the arbiter is not built for.
  if (NREQ < 2 || NREQ > 8 || N == 0 || TIMEOUT == 0) begin : g_cfg_check
    $error("mm_iddmm_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      mm_type_q, mm_type_d;
  logic            mm_start_q, mm_start_d;
  logic [K-1:0]    mm_x_q, mm_x_d;
  logic [K-1:0]    mm_y_q, mm_y_d;
  logic            mm_xv_q, mm_xv_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            rsp_hit_c;

`ifdef MM_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  // Round-robin search: first set req bit at or above rr_q, wrapping.
  int unsigned     pos;
  logic [IW-1:0]   cand;
  logic            win_found;
  logic [IW-1:0]   win_idx;

  always_comb begin
    pos       = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = 32'(rr_q) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IW'(pos);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Per-requester field selection: type of the candidate, stream of the owner.
  logic [1:0]   sel_type;
  logic [K-1:0] sel_x, sel_y;
  logic         sel_xv, sel_yv;

  always_comb begin
    sel_type = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_xv   = 1'b0;
    sel_yv   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) sel_type = req_type[2*i +: 2];
      if (g_q == IW'(i)) begin
        sel_x  = req_x[K*i +: K];
        sel_y  = req_y[K*i +: K];
        sel_xv = req_x_valid[i];
        sel_yv = req_y_valid[i];
      end
    end
  end

  logic [NREQ-1:0] win_oh, g_oh;
  logic [IW-1:0]   rr_next;

  assign win_oh  = NREQ'(1) << win_idx;
  assign g_oh    = NREQ'(1) << g_q;
  assign rr_next = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    g_d        = g_q;
    word_cnt_d = word_cnt_q;
    res_cnt_d  = res_cnt_q;
    gnt_d      = '0;
    mm_type_d  = mm_type_q;
    mm_start_d = 1'b0;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    mm_xv_d    = 1'b0;
    err_d      = '0;
    rsp_hit_c  = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          g_d        = win_idx;
          gnt_d      = win_oh;
          mm_type_d  = sel_type;
          word_cnt_d = '0;
          res_cnt_d  = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        mm_start_d = 1'b1;
        state_d    = S_LOAD;
      end

      // Only a paired x/y valid from the owner counts as a word.
      S_LOAD: begin
        if (sel_xv && sel_yv) begin
          mm_x_d  = sel_x;
          mm_y_d  = sel_y;
          mm_xv_d = 1'b1;
          if (word_cnt_q == CW'(N - 1)) begin
            state_d = S_WAIT;
`ifdef MM_ARB_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end

      // The first mm_valid seen here is already result word 0.
      S_WAIT: begin
        if (mm_valid) begin
          rsp_hit_c = 1'b1;
          if (N == 1) begin
            state_d   = S_IDLE;
            rr_d      = rr_next;
            mm_type_d = '0;
          end else begin
            res_cnt_d = CW'(1);
            state_d   = S_DRAIN;
          end
        end
`ifdef MM_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d     = g_oh;
          state_d   = S_IDLE;
          rr_d      = rr_next;
          mm_type_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end

      S_DRAIN: begin
        if (mm_valid) begin
          rsp_hit_c = 1'b1;
          if (res_cnt_q == CW'(N - 1)) begin
            state_d   = S_IDLE;
            rr_d      = rr_next;
            mm_type_d = '0;
          end else begin
            res_cnt_d = res_cnt_q + CW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      g_q        <= '0;
      word_cnt_q <= '0;
      res_cnt_q  <= '0;
      gnt_q      <= '0;
      mm_type_q  <= '0;
      mm_start_q <= 1'b0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      mm_xv_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      g_q        <= g_d;
      word_cnt_q <= word_cnt_d;
      res_cnt_q  <= res_cnt_d;
      gnt_q      <= gnt_d;
      mm_type_q  <= mm_type_d;
      mm_start_q <= mm_start_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      mm_xv_q    <= mm_xv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef MM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Result words pass straight through to the owner; suppressed while in reset.
  assign rsp_valid  = (rsp_hit_c && !rst) ? g_oh : '0;
  assign rsp_data   = (rsp_hit_c && !rst) ? mm_result : '0;

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mm_type    = mm_type_q;
  assign mm_start   = mm_start_q;
  assign mm_x       = mm_x_q;
  assign mm_y       = mm_y_q;
  assign mm_x_valid = mm_xv_q;
  assign mm_y_valid = mm_xv_q;

endmodule

// File: tb/tb_mm_iddmm_arbiter.sv
// Scoreboard bench for mm_iddmm_arbiter: stimulus pushes expected grants,
// start types, operand words, result words and aborts; a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_mm_iddmm_arbiter;

  localparam int unsigned K    = 256;
  localparam int unsigned N    = 16;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TMO  = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   req_type;
  logic [K*NREQ-1:0]   req_x, req_y;
  logic [NREQ-1:0]     req_x_valid, req_y_valid;
  logic [NREQ-1:0]     gnt, rsp_valid, err;
  logic [K-1:0]        rsp_data, mm_x, mm_y, mm_result;
  logic                busy, mm_start, mm_x_valid, mm_y_valid, mm_valid;
  logic [1:0]          mm_type;

  mm_iddmm_arbiter #(.K(K), .N(N), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type),
    .req_x(req_x), .req_x_valid(req_x_valid),
    .req_y(req_y), .req_y_valid(req_y_valid),
    .gnt(gnt), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .busy(busy), .err(err), .mm_type(mm_type), .mm_start(mm_start),
    .mm_x(mm_x), .mm_x_valid(mm_x_valid), .mm_y(mm_y), .mm_y_valid(mm_y_valid),
    .mm_result(mm_result), .mm_valid(mm_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [K-1:0] x; logic [K-1:0] y; } xy_t;
  typedef struct packed { logic [NREQ-1:0] oh; logic [K-1:0] d; } rsp_t;

  logic [NREQ-1:0] exp_gnt[$];
  logic [1:0]      exp_type[$];
  xy_t             exp_xy[$];
  rsp_t            exp_rsp[$];
  logic [NREQ-1:0] exp_err[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", K'(gnt), '0);
      else                     chk("gnt", K'(gnt), K'(exp_gnt.pop_front()));
    end
    if (mm_start) begin
      if (exp_type.size() == 0) chk("start_unexpected", K'(mm_start), '0);
      else                      chk("mm_type", K'(mm_type), K'(exp_type.pop_front()));
    end
    if (mm_x_valid || mm_y_valid) begin
      chk("valid_pair", K'(mm_y_valid), K'(mm_x_valid));
      if (exp_xy.size() == 0) chk("mm_x_unexpected", K'(mm_x_valid), '0);
      else begin
        xy_t e;
        e = exp_xy.pop_front();
        chk("mm_x", mm_x, e.x);
        chk("mm_y", mm_y, e.y);
      end
    end
    if (rsp_valid != '0) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", K'(rsp_valid), '0);
      else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        chk("rsp_valid", K'(rsp_valid), K'(r.oh));
        chk("rsp_data", rsp_data, r.d);
      end
    end
    if (err != '0) begin
      if (exp_err.size() == 0) chk("err_unexpected", K'(err), '0);
      else                     chk("err", K'(err), K'(exp_err.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_grant(input int r);
    exp_gnt.push_back(NREQ'(1) << r);
    exp_type.push_back(req_type[2*r +: 2]);
  endtask

  task automatic wait_gnt(input int r);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = gnt[r];
    end
    if (!seen) chk("gnt_wait", K'(gnt), K'(NREQ'(1) << r));
    else       chk("busy_at_gnt", K'(busy), K'(1));
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", K'(busy), '0);
    tick();
  endtask

  // Stream nw operand words from requester r; optional 3-cycle gaps every
  // 4 words, optionally with a stray mm_valid inside the first gap.
  task automatic drive_words(input int r, input int xb, input int yb, input int nw,
                             input bit stall, input bit spur);
    for (int i = 0; i < nw; i++) begin
      if (stall && i > 0 && (i % 4) == 0) begin
        req_x_valid[r] = 1'b0;
        req_y_valid[r] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          if (spur && i == 4 && s == 1) begin
            mm_valid  = 1'b1;
            mm_result = K'(32'hDEAD);
          end
          tick();
          mm_valid = 1'b0;
        end
      end
      req_x[r*K +: K] = K'(xb + i);
      req_y[r*K +: K] = K'(yb + i);
      req_x_valid[r]  = 1'b1;
      req_y_valid[r]  = 1'b1;
      exp_xy.push_back('{x: K'(xb + i), y: K'(yb + i)});
      tick();
    end
    req_x_valid[r] = 1'b0;
    req_y_valid[r] = 1'b0;
  endtask

  // Multiplier model: N result words base+i to owner r, optional mid gap.
  task automatic respond(input int r, input int base, input bit gap);
    repeat (3) tick();
    for (int i = 0; i < int'(N); i++) begin
      if (gap && i == 8) begin
        mm_valid = 1'b0;
        tick();
      end
      mm_result = K'(base + i);
      mm_valid  = 1'b1;
      exp_rsp.push_back('{oh: NREQ'(1) << r, d: K'(base + i)});
      tick();
    end
    mm_valid  = 1'b0;
    mm_result = '0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_gnt"},       K'(gnt), '0);
    chk({tag, "_rsp_valid"}, K'(rsp_valid), '0);
    chk({tag, "_rsp_data"},  rsp_data, '0);
    chk({tag, "_busy"},      K'(busy), '0);
    chk({tag, "_err"},       K'(err), '0);
    chk({tag, "_mm_type"},   K'(mm_type), '0);
    chk({tag, "_mm_start"},  K'(mm_start), '0);
    chk({tag, "_mm_x"},      mm_x, '0);
    chk({tag, "_mm_y"},      mm_y, '0);
    chk({tag, "_mm_xv"},     K'(mm_x_valid), '0);
    chk({tag, "_mm_yv"},     K'(mm_y_valid), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc;
    rst = 1'b1; req = '0; req_x = '0; req_y = '0;
    req_x_valid = '0; req_y_valid = '0; mm_valid = 1'b0; mm_result = '0;
    req_type = {2'd1, 2'd1};
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");
    tick();

    // Stray mm_valid while idle must not produce a response.
    mm_valid = 1'b1; mm_result = K'(32'hBAD); tick(); mm_valid = 1'b0; mm_result = '0;

    // Single request from 0, type 1; requester 1 valids must be ignored.
    expect_grant(0);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    req_x[K +: K] = K'(32'h777); req_y[K +: K] = K'(32'h888);
    req_x_valid[1] = 1'b1; req_y_valid[1] = 1'b1;
    drive_words(0, 0, 16, 16, 1'b0, 1'b0);
    req_x_valid[1] = 1'b0; req_y_valid[1] = 1'b0;
    respond(0, 32'hA0, 1'b0);
    wait_idle();

    // Stalled stream from 1 with a stray mm_valid during LOAD.
    req_type = {2'd2, 2'd1};
    expect_grant(1);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    drive_words(1, 32'h100, 32'h200, 16, 1'b1, 1'b1);
    respond(1, 32'hB0, 1'b1);
    wait_idle();

    // Contention: both held, grants must rotate 0,1,0.
    req_type = {2'd1, 2'd3};
    expect_grant(0); expect_grant(1); expect_grant(0);
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      int w;
      w = (t == 1) ? 1 : 0;
      wait_gnt(w);
      if (t == 2) req = 2'b00;
      drive_words(w, 32'h300 + 32*t, 32'h400 + 32*t, 16, 1'b0, 1'b0);
      respond(w, 32'hC0 + 32*t, 1'b0);
      wait_idle();
    end

    // Unpaired x_valid for 5 cycles is neither counted nor forwarded.
    expect_grant(0);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    req_x[0 +: K] = K'(32'h55);
    req_x_valid[0] = 1'b1; req_y_valid[0] = 1'b0;
    repeat (5) tick();
    req_x_valid[0] = 1'b0;
    chk("unpaired_no_xv", K'(mm_x_valid), '0);
    drive_words(0, 32'h500, 32'h600, 16, 1'b0, 1'b0);
    respond(0, 32'hD0, 1'b0);
    wait_idle();

    // Reset after 7 words of a grant to 1 (rr_ptr is 1 here).
    expect_grant(1);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    drive_words(1, 32'h700, 32'h800, 7, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midreset");
    tick();

    // After reset rr_ptr is 0, so requester 0 wins over 1; 1 then withdraws.
    expect_grant(0);
    req = 2'b11;
    wait_gnt(0);
    req = 2'b00;
    drive_words(0, 32'h900, 32'hA00, 16, 1'b0, 1'b0);
    respond(0, 32'hE0, 1'b0);
    wait_idle();
    repeat (5) tick();

`ifdef MM_ARB_TIMEOUT_EN
    // No result: owner 1 aborted after TMO WAIT cycles, then 0 is granted.
    expect_grant(1);
    exp_err.push_back(2'b10);
    expect_grant(0);
    req = 2'b11;
    wait_gnt(1);
    drive_words(1, 32'hB00, 32'hC00, 16, 1'b0, 1'b0);
    a_cyc = cyc;
    begin
      int n = 0;
      while (err == '0 && n < int'(TMO) + 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("tmo_cycles", K'(cyc - a_cyc), K'(TMO));
    @(negedge clk);
    chk("tmo_busy", K'(busy), '0);
    wait_gnt(0);
    req = 2'b00;
    drive_words(0, 32'hD00, 32'hE00, 16, 1'b0, 1'b0);
    respond(0, 32'hF0, 1'b0);
    wait_idle();
`else
    // Without the timeout feature WAIT holds indefinitely and err stays 0.
    expect_grant(1);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    drive_words(1, 32'hB00, 32'hC00, 16, 1'b0, 1'b0);
    a_cyc = cyc;
    repeat (80) tick();
    chk("wait_busy", K'(busy), K'(1));
    chk("wait_err", K'(err), '0);
    chk("wait_elapsed", K'(cyc - a_cyc), K'(80));
    respond(1, 32'hF0, 1'b0);
    wait_idle();
`endif

    repeat (5) tick();
    chk("left_gnt",  K'(exp_gnt.size()), '0);
    chk("left_type", K'(exp_type.size()), '0);
    chk("left_xy",   K'(exp_xy.size()), '0);
    chk("left_rsp",  K'(exp_rsp.size()), '0);
    chk("left_err",  K'(exp_err.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_arbiter.md
Name: mm_iddmm_arbiter

Overview:
- Shares one mm_iddmm_top Montgomery multiplier between NREQ requesters, for example the encrypt and decrypt exponentiation engines.
- Arbitrates round-robin and issues the one-cycle mm_start pulse with the granted mm_type.
- Forwards the granted requester's N-word x/y operand stream to the multiplier, then routes the N-word result stream back to that requester only.
- Sits directly in front of mm_iddmm_top; requesters see a start/grant/stream/response protocol.

Parameters:
- K, 256, operand word width in bits
- N, 16, words per operand (operand width K*N)
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 4096, max cycles in WAIT before abort (timeout feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  request level per requester; held until gnt
- req_type  in  2*NREQ  mm_type per requester, slice i = [2i+:2]; sampled at grant
- req_x  in  K*NREQ  x word per requester, slice [iK+:K]
- req_x_valid  in  NREQ  x word valid
- req_y  in  K*NREQ  y word per requester
- req_y_valid  in  NREQ  y word valid
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- rsp_data  out  K  result word, shared bus
- rsp_valid  out  NREQ  one-hot result-word valid
- busy  out  1  high in any state except IDLE
- err  out  NREQ  one-cycle timeout-abort pulse (tied 0 without feature)
- mm_type  out  2  to multiplier
- mm_start  out  1  to multiplier
- mm_x  out  K  to multiplier
- mm_x_valid  out  1  to multiplier
- mm_y  out  K  to multiplier
- mm_y_valid  out  1  to multiplier
- mm_result  in  K  from multiplier
- mm_valid  in  1  from multiplier

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, rr_ptr=0, all counters=0.
- Reset values: all outputs 0, including gnt, rsp_valid, err, busy, mm_start, mm_x/y, mm_*_valid, mm_type.
- rst mid-operation aborts immediately; no further rsp_valid or err is issued.
- States: IDLE -> START -> LOAD -> WAIT -> DRAIN -> IDLE.
- IDLE: the first set req bit found searching from rr_ptr upward (wrapping) wins.
  - Winner captured as g; gnt[g]=1 for exactly one cycle.
  - mm_type <= req_type[g]; go to START. mm_type holds until IDLE is re-entered.
- START: mm_start=1 for exactly one cycle; go to LOAD.
- Requester stream rule: first word is presented no earlier than the cycle after gnt; x_valid and y_valid are asserted together.
- LOAD: a word is accepted when req_x_valid[g] & req_y_valid[g].
  - Accepted word registered: mm_x/mm_y <= word, mm_x_valid = mm_y_valid = 1 the next cycle (latency 1).
  - Gaps allowed: valids deasserted while the requester stalls.
  - word_cnt counts 0..N-1; on the N-th accepted word go to WAIT.
  - Valids from non-granted requesters are ignored.
  - x_valid without y_valid (or vice versa) is not accepted and not counted.
- WAIT: on mm_valid=1, go to DRAIN; that cycle's word is result word 0.
- DRAIN: rsp_data = mm_result (combinational passthrough, latency 0); rsp_valid[g] = mm_valid.
  - Result word count includes word 0 from WAIT.
  - After N result words (LSW first) go to IDLE and set rr_ptr = (g+1) mod NREQ.
- req raised by a requester during a busy period waits in line; a grant can issue in the first IDLE cycle after DRAIN.
- req deasserted before gnt drops that request; no state change.
- If all req bits are set continuously, grants rotate 0,1,...,NREQ-1,0,...
- mm_valid while in IDLE/START/LOAD is ignored.
- busy=1 in START/LOAD/WAIT/DRAIN.

Optional Feature:
- Macro: MM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT without mm_valid: err[g] pulses one cycle, state -> IDLE, rr_ptr advances as for normal completion.
  - A late mm_valid after abort is ignored.
- Undefined: no counter; WAIT holds indefinitely; err is constant 0.

Test Plan:
- Single request: req=2'b01, type=1, 16 words x=i, y=16+i.
  - gnt=01 one cycle, then mm_start one cycle with mm_type=1.
  - mm_x_valid for 16 cycles, mm_x=i one cycle after acceptance.
  - Model returns 16 words 0xA0+i: rsp_valid=01 for 16 cycles, rsp_data in order.
- Contention: req=2'b11 held for 3 transactions -> grant order 0,1,0; responses never on the wrong rsp_valid bit.
- Stalled stream: requester 1 inserts 3-cycle gaps every 4 words -> exactly 16 mm_x_valid pulses; WAIT entered only after word 16.
- Invalid handshake: x_valid=1 with y_valid=0 for 5 cycles in LOAD -> no words counted, no mm_x_valid.
- Reset mid-LOAD after 7 words -> all outputs 0 next cycle; a new req=01 completes a full 16-word transaction normally.
- MM_ARB_TIMEOUT_EN, TIMEOUT=64, model never asserts mm_valid -> err[g] pulses after 64 WAIT cycles, busy drops, the next requester is granted.
